// File: rtl/mips_bus_master.sv
// Bus initiator for the MIPS core: turns one load/store request at a time into a
// word-addressed bus transaction and returns the lane-extracted load result.
module mips_bus_master #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [1:0]  state_dbg
);
    // Handshake: a request transfers on a clock edge where req_valid and req_ready
    // are both high; the response is a single-cycle rsp_valid pulse with no backpressure.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    state_t      state, state_next;

    logic        lat_write, lat_write_next;
    logic        lat_signed, lat_signed_next;
    logic [1:0]  lat_size, lat_size_next;
    logic [1:0]  lat_lane, lat_lane_next;
    logic [15:0] wait_cnt, wait_cnt_next;
    logic [15:0] wait_cnt_inc;
    logic        wait_expired;

    logic [31:0] address_next;
    logic        read_next, write_next;
    logic [31:0] writedata_next;
    logic [3:0]  byteenable_next;
    logic        rsp_valid_next;
    logic [31:0] rsp_rdata_next;
    logic        rsp_err_next;

    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign state_dbg = state;

    assign wait_cnt_inc = wait_cnt + 16'd1;
    assign wait_expired = (TIMEOUT_LIMIT != 32'd0) && ({16'd0, wait_cnt_inc} == TIMEOUT_LIMIT);

    // Size 11 has no legal encoding, so it is rejected the same way as a misaligned access.
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        req_be = 4'b1111;
        req_wd = req_wdata;
        case (req_size)
            2'b00: begin
                req_be = 4'b0001 << req_addr[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be = 4'b0011 << {req_addr[1], 1'b0};
                req_wd = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be = 4'b1111;
                req_wd = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_byte = readdata[7:0];
        case (lat_lane)
            2'd0:    lane_byte = readdata[7:0];
            2'd1:    lane_byte = readdata[15:8];
            2'd2:    lane_byte = readdata[23:16];
            default: lane_byte = readdata[31:24];
        endcase
        lane_half = lat_lane[1] ? readdata[31:16] : readdata[15:0];
        case (lat_size)
            2'b00:   load_data = {{24{lat_signed & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{lat_signed & lane_half[15]}}, lane_half};
            default: load_data = readdata;
        endcase
    end

    always_comb begin
        state_next      = state;
        lat_write_next  = lat_write;
        lat_signed_next = lat_signed;
        lat_size_next   = lat_size;
        lat_lane_next   = lat_lane;
        wait_cnt_next   = wait_cnt;
        address_next    = address;
        read_next       = read;
        write_next      = write;
        writedata_next  = writedata;
        byteenable_next = byteenable;
        rsp_valid_next  = 1'b0;
        rsp_rdata_next  = rsp_rdata;
        rsp_err_next    = rsp_err;

        case (state)
            IDLE: begin
                read_next  = 1'b0;
                write_next = 1'b0;
                if (req_valid) begin
                    lat_write_next  = req_write;
                    lat_signed_next = req_signed;
                    lat_size_next   = req_size;
                    lat_lane_next   = req_addr[1:0];
                    if (req_misaligned) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = 32'd0;
                    end else begin
                        state_next      = BUS;
                        wait_cnt_next   = 16'd0;
                        address_next    = {req_addr[31:2], 2'b00};
                        read_next       = ~req_write;
                        write_next      = req_write;
                        writedata_next  = req_wd;
                        byteenable_next = req_be;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    if (lat_write) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b0;
                        rsp_rdata_next = 32'd0;
                    end else begin
                        state_next = RDATA;
                    end
                end else if (wait_expired) begin
                    read_next      = 1'b0;
                    write_next     = 1'b0;
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = 32'd0;
                end else begin
                    wait_cnt_next = wait_cnt_inc;
                end
            end
            RDATA: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_rdata_next = load_data;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_write  <= 1'b0;
            lat_signed <= 1'b0;
            lat_size   <= 2'b00;
            lat_lane   <= 2'b00;
            wait_cnt   <= 16'd0;
            address    <= 32'd0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'd0;
            byteenable <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            lat_write  <= lat_write_next;
            lat_signed <= lat_signed_next;
            lat_size   <= lat_size_next;
            lat_lane   <= lat_lane_next;
            wait_cnt   <= wait_cnt_next;
            address    <= address_next;
            read       <= read_next;
            write      <= write_next;
            writedata  <= writedata_next;
            byteenable <= byteenable_next;
            rsp_valid  <= rsp_valid_next;
            rsp_rdata  <= rsp_rdata_next;
            rsp_err    <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_mips_bus_master.sv
// Bench for mips_bus_master: byte-level memory reference model, bus slave with
// programmable stalls, directed cases followed by randomized load/store traffic.
module tb_mips_bus_master;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;
    logic [1:0]  state_dbg;

    mips_bus_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference memory, one byte per location, 64 bytes wide window.
    logic [7:0]  ref_mem [0:63];

    // Bus slave memory and bookkeeping.
    logic [31:0] mem [0:15];
    int          stall_cfg = 0;
    bit          stuck = 1'b0;
    int          stall_left = 0;
    bit          bus_busy = 1'b0;
    bit          rd_pending = 1'b0;
    logic [3:0]  rd_idx = 4'd0;
    int          strobe_seen = 0;
    int          accepts = 0;
    bit          unstable = 1'b0;
    bit          both_seen = 1'b0;
    logic [31:0] snap_addr, snap_wd;
    logic [3:0]  snap_be;
    logic        snap_rd;
    int          snap_cycles = 0;
    logic [31:0] obs_addr = 32'd0, obs_wd = 32'd0;
    logic [3:0]  obs_be = 4'd0;
    logic        obs_rd = 1'b0;
    int          obs_cycles = 0;

    always @(negedge clk) begin
        if (reset) begin
            waitrequest = 1'b0;
            bus_busy    = 1'b0;
            rd_pending  = 1'b0;
        end else begin
            if (rd_pending) begin
                readdata   = mem[rd_idx];
                rd_pending = 1'b0;
            end else begin
                readdata = $urandom;
            end
            if (read || write) begin
                if (read && write) both_seen = 1'b1;
                strobe_seen++;
                if (!bus_busy) begin
                    bus_busy    = 1'b1;
                    stall_left  = stall_cfg;
                    snap_addr   = address;
                    snap_be     = byteenable;
                    snap_wd     = writedata;
                    snap_rd     = read;
                    snap_cycles = 0;
                    unstable    = 1'b0;
                end else if (address != snap_addr || byteenable != snap_be ||
                             writedata != snap_wd || read != snap_rd) begin
                    unstable = 1'b1;
                end
                snap_cycles++;
                if (stuck || stall_left > 0) begin
                    waitrequest = 1'b1;
                    if (stall_left > 0) stall_left--;
                end else begin
                    waitrequest = 1'b0;
                    bus_busy    = 1'b0;
                    accepts++;
                    obs_addr   = snap_addr;
                    obs_be     = snap_be;
                    obs_wd     = snap_wd;
                    obs_rd     = snap_rd;
                    obs_cycles = snap_cycles;
                    if (read) begin
                        rd_pending = 1'b1;
                        rd_idx     = address[5:2];
                    end else begin
                        for (int l = 0; l < 4; l++)
                            if (byteenable[l]) mem[address[5:2]][l*8 +: 8] = writedata[l*8 +: 8];
                    end
                end
            end else begin
                waitrequest = 1'($urandom_range(0, 1));
                bus_busy    = 1'b0;
            end
        end
    end

    task automatic poke_word(input int idx, input logic [31:0] val);
        mem[idx] = val;
        for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = val[b*8 +: 8];
    endtask

    // Driver: issue one request, follow it to its response and score it.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                          input bit sgn, input logic [31:0] wdata, input int stalls,
                          input bit stk, output logic [31:0] got_rdata);
        int n, exp_lat, lat, guard, seen0, acc0, a;
        bit mis, exp_err;
        logic [31:0] exp, exp_wd, exp_rd;
        logic [3:0]  exp_be;

        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (size == 2'd3) || ((addr % n) != 0);
        exp_err = mis || stk;
        exp = 32'd0;
        if (!exp_err && !wr) begin
            for (int i = 0; i < n; i++) begin
                a = int'((addr + i) & 32'd63);
                exp = exp | (32'(ref_mem[a]) << (8 * i));
            end
            if (sgn && n < 4 && exp[8*n-1]) exp = exp | (32'hFFFF_FFFF << (8 * n));
        end
        exp_be = 4'd0;
        for (int i = 0; i < n; i++) exp_be[(addr[1:0] + i) % 4] = 1'b1;
        for (int l = 0; l < 4; l++) exp_wd[l*8 +: 8] = wdata[(l % n)*8 +: 8];
        exp_lat = mis ? 1 : stk ? 1 + TIMEOUT : (wr ? 2 : 3) + stalls;
        if (wr && !exp_err)
            for (int i = 0; i < n; i++) ref_mem[int'((addr + i) & 32'd63)] = wdata[i*8 +: 8];
        exp_q.push_back(exp);

        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_wait", {31'd0, req_ready}, 32'd1);
        stall_cfg  = stalls;
        stuck      = stk;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        seen0 = strobe_seen;
        acc0  = accepts;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_wdata  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        exp_rd = exp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        got_rdata = rsp_rdata;
        check_eq("strobes_low_at_rsp", {30'd0, read, write}, 32'd0);
        if (mis) begin
            check_eq("mis_no_bus", strobe_seen - seen0, 0);
        end else if (stk) begin
            check_eq("timeout_no_accept", accepts - acc0, 0);
            check_eq("timeout_strobe_cycles", strobe_seen - seen0, TIMEOUT);
        end else begin
            check_eq("bus_accepts", accepts - acc0, 1);
            check_eq("bus_kind", {31'd0, obs_rd}, {31'd0, ~wr});
            check_eq("bus_address", obs_addr, {addr[31:2], 2'b00});
            check_eq("bus_byteenable", {28'd0, obs_be}, {28'd0, exp_be});
            check_eq("bus_strobe_cycles", obs_cycles, stalls + 1);
            check_eq("bus_stable", {31'd0, unstable}, 32'd0);
            if (wr) check_eq("bus_writedata", obs_wd, exp_wd);
        end
        @(negedge clk);
        stuck     = 1'b0;
        stall_cfg = 0;
        check_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check_eq("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        int rsp_cnt, stalls;
        bit wr, stk;
        logic [1:0] size;

        for (int w = 0; w < 16; w++) poke_word(w, $urandom);

        repeat (3) @(negedge clk);
        check_eq("reset_ready", {31'd0, req_ready}, 32'd1);
        check_eq("reset_strobes", {30'd0, read, write}, 32'd0);
        check_eq("reset_address", address, 32'd0);
        check_eq("reset_writedata", writedata, 32'd0);
        check_eq("reset_byteenable", {28'd0, byteenable}, 32'd0);
        check_eq("reset_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        poke_word(1, 32'h1234_5678);
        do_req(1'b0, 32'hBFC0_0004, 2'b10, 1'b0, 32'd0, 0, 1'b0, got);
        check_eq("word_load_value", got, 32'h1234_5678);

        poke_word(1, 32'h8011_2233);
        do_req(1'b0, 32'hBFC0_0007, 2'b00, 1'b1, 32'd0, 0, 1'b0, got);
        check_eq("byte_load_signed", got, 32'hFFFF_FF80);
        do_req(1'b0, 32'hBFC0_0007, 2'b00, 1'b0, 32'd0, 0, 1'b0, got);
        check_eq("byte_load_unsigned", got, 32'h0000_0080);

        poke_word(0, 32'hCAFE_1234);
        do_req(1'b1, 32'hBFC0_0002, 2'b01, 1'b0, 32'h0000_BEEF, 0, 1'b0, got);
        do_req(1'b0, 32'hBFC0_0000, 2'b10, 1'b0, 32'd0, 0, 1'b0, got);
        check_eq("half_store_readback", got, 32'hBEEF_1234);

        do_req(1'b1, 32'hBFC0_0008, 2'b10, 1'b0, 32'hA5A5_0F0F, 3, 1'b0, got);
        do_req(1'b1, 32'hBFC0_000C, 2'b10, 1'b0, 32'h0102_0304, TIMEOUT - 1, 1'b0, got);
        do_req(1'b0, 32'hBFC0_0001, 2'b01, 1'b0, 32'd0, 0, 1'b0, got);
        do_req(1'b1, 32'hBFC0_0004, 2'b11, 1'b0, 32'h1111_1111, 0, 1'b0, got);
        do_req(1'b0, 32'hBFC0_0010, 2'b10, 1'b0, 32'd0, 0, 1'b1, got);
        do_req(1'b1, 32'hBFC0_0014, 2'b00, 1'b0, 32'h0000_0077, 0, 1'b1, got);

        for (int t = 0; t < 150; t++) begin
            wr     = 1'($urandom_range(0, 1));
            size   = 2'($urandom_range(0, 3));
            stalls = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
            stk    = ($urandom_range(0, 29) == 0);
            do_req(wr, 32'hBFC0_0000 | 32'($urandom_range(0, 63)), size,
                   1'($urandom_range(0, 1)), $urandom, stalls, stk, got);
        end

        // Reset in the middle of a stalled read.
        stuck = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFC0_0010;
        req_size = 2'b10; req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_read_before", {31'd0, read}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_read_drop", {31'd0, read}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        stuck = 1'b0;
        reset = 1'b0;
        rsp_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
        end
        check_eq("rst_no_rsp", rsp_cnt, 0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_address", address, 32'd0);

        do_req(1'b0, 32'hBFC0_0000, 2'b10, 1'b0, 32'd0, 1, 1'b0, got);

        check_eq("strobes_exclusive", {31'd0, both_seen}, 32'd0);
        check_eq("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_bus_master.md
# mips_bus_master

Bus initiator that turns single load/store requests from the CPU core into transactions on the word-addressed memory bus (address/read/write/writedata/byteenable/waitrequest/readdata) served by the RAM model and memory slaves. It drives the byte lanes, honours waitrequest, captures read data with fixed one-cycle latency, and returns lane-extracted, sign- or zero-extended results to the core. It sits between the core's load/store stage and the top-level bus ports of mips_cpu_bus.

## Interface
- TIMEOUT_CYCLES, 0: waitrequest cycles before an error abort; 0 disables the timeout.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block idle and accepting a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_signed  in  1  sign-extend loads (byte/half only)
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned request or timeout
- address  out  32  {req_addr[31:2],2'b00}
- read, write  out  1  bus strobes, mutually exclusive
- writedata  out  32  lane-replicated store data
- byteenable  out  4  active lanes; bit n covers data[8n+7:8n]
- waitrequest  in  1  slave stall
- readdata  in  32  read data, valid the cycle after acceptance

## Operation
- States: IDLE, BUS, RDATA, RESP.
- IDLE: req_ready=1 and bus strobes low. req_valid is sampled at the clock edge and the request fields are latched.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, size 11): go to RESP with err=1. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS: assert read or write with address, byteenable and writedata held stable.
  - Byte: byteenable = 4'b0001<<addr[1:0]; writedata = {4{wdata[7:0]}}.
  - Half: byteenable = 4'b0011<<{addr[1],1'b0}; writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 4'b1111; writedata = wdata.
  - Acceptance is an edge where waitrequest=0. A write then goes to RESP; a read goes to RDATA.
  - A 16-bit wait counter clears on entering BUS and increments every edge that waitrequest=1. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES, drop the strobes and go to RESP with err=1.
- RDATA: strobes low. Capture readdata at the end of the cycle, then extract the lanes:
  - Byte: lane addr[1:0].
  - Half: bytes {addr[1],1}:{addr[1],0}.
  - Sign-extend when req_signed=1, otherwise zero-extend. Words are passed through unchanged.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err registered. Next state is IDLE.
- There is no response backpressure. The core must consume rsp_valid in the cycle it is asserted.

## Timing
- Reset (asynchronous): state IDLE; req_ready=1; read=write=0; address, writedata, byteenable, rsp_rdata = 0; rsp_valid=rsp_err=0; wait counter 0.
- Reset asserted mid-transaction: strobes drop immediately, the transaction is abandoned, and no rsp_valid is produced.
- Latency with no stalls, counting the accept edge as cycle 0:
  - BUS in cycle 1.
  - Store: rsp_valid in cycle 2.
  - Load: RDATA in cycle 2, rsp_valid in cycle 3.
- Each waitrequest cycle adds one cycle of latency.
- Misaligned request: rsp_valid in cycle 1 and the bus stays idle.
- Back-to-back operation: req_ready returns to 1 in the cycle after RESP. The minimum request interval is 3 cycles for stores and 4 for loads.
- Bus outputs are registered and change only on clock edges, except on reset.

## Test plan
- Word load at 0xBFC00004, memory word 0x12345678, waitrequest=0 → read=1 for 1 cycle with byteenable=1111; rsp_valid in cycle 3 with rsp_rdata=0x12345678 and err=0.
- Signed byte load at 0xBFC00007 with lane 3 = 0x80 → byteenable=1000, rsp_rdata=0xFFFFFF80. The same load unsigned → 0x00000080.
- Half store of 0xBEEF at 0xBFC00002 → write=1, byteenable=1100, writedata=0xBEEFBEEF; a following word load returns 0xBEEFxxxx with the low half unchanged.
- waitrequest held high 3 cycles on a word store → strobes and address held stable for 4 cycles, rsp_valid 3 cycles later than the no-stall case.
- Half load at 0xBFC00001 → rsp_valid in cycle 1 with err=1, read never asserted. With TIMEOUT_CYCLES=8 and waitrequest stuck high → err=1 response after 8 stall edges and strobes low.
- Reset asserted during BUS with waitrequest=1 → read falls immediately, no rsp_valid, req_ready=1 after reset.
